clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 168 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk cycles.
// Define CLK_PERIOD_METER_DUTY_EN to include high-time measurement; otherwise high_time reads 0.
module clk_period_meter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_in,
  input  logic        enable,
  input  logic [31:0] timeout,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        locked,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
  logic        stall_q, stall_d;
  logic        rise;
  logic [31:0] cnt_inc;
  logic        timeout_hit;

  // Two flops resolve metastability; the third holds the previous synced level.
  assign rise = sync2_q & ~prev_q;

  // Saturating increment: the count sticks at all-ones rather than wrapping.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 32'd1;
  assign timeout_hit = (timeout != 32'd0) && (cnt_inc >= timeout);

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] high_time_q, high_time_d;
  logic [31:0] hcnt_inc;

  assign hcnt_inc = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 32'd1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stall_d  = 1'b0;
    locked_d = locked_q;
`ifdef CLK_PERIOD_METER_DUTY_EN
    hcnt_d      = hcnt_q;
    high_time_d = high_time_q;
`endif

    if (!enable) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
      cnt_d    = 32'd0;
`ifdef CLK_PERIOD_METER_DUTY_EN
      hcnt_d   = 32'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = 32'd0;
`ifdef CLK_PERIOD_METER_DUTY_EN
          hcnt_d  = 32'd0;
`endif
          state_d = S_ARM;
        end

        S_ARM: begin
          if (rise) begin
            state_d = S_MEASURE;
            cnt_d   = 32'd0;
`ifdef CLK_PERIOD_METER_DUTY_EN
            hcnt_d  = 32'd1;
`endif
          end
        end

        S_MEASURE: begin
          // A rise takes priority over a coincident timeout.
          if (rise) begin
            period_d    = cnt_inc;
            valid_d     = 1'b1;
            locked_d    = 1'b1;
            cnt_d       = 32'd0;
`ifdef CLK_PERIOD_METER_DUTY_EN
            high_time_d = hcnt_q;
            hcnt_d      = 32'd1;
`endif
          end else if (timeout_hit) begin
            stall_d  = 1'b1;
            locked_d = 1'b0;
            state_d  = S_ARM;
            cnt_d    = 32'd0;
`ifdef CLK_PERIOD_METER_DUTY_EN
            hcnt_d   = 32'd0;
`endif
          end else begin
            cnt_d = cnt_inc;
`ifdef CLK_PERIOD_METER_DUTY_EN
            if (sync2_q) hcnt_d = hcnt_inc;
`endif
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      period_q <= 32'd0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      sync1_q  <= clk_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      stall_q  <= stall_d;
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q      <= 32'd0;
      high_time_q <= 32'd0;
    end else begin
      hcnt_q      <= hcnt_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  assign high_time = 32'd0;
`endif

  assign period = period_q;
  assign valid  = valid_q;
  assign locked = locked_q;
  assign stall  = stall_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: clk_in is driven synchronously so every latency is exact.
module tb_clk_period_meter;

  logic        clk;
  logic        rst;
  logic        clk_in;
  logic        enable;
  logic [31:0] timeout;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        locked;
  logic        stall;

  int vectors     = 0;
  int miscompares = 0;

  // Pulse bookkeeping, written only by the monitor process.
  int valid_cnt = 0;
  int stall_cnt = 0;
  int both_cnt  = 0;
  int cyc       = 0;
  int last_valid_cyc = 0;
  int last_gap  = 0;

  int v0;
  int s0;
  logic [31:0] exp_ht5;
  logic [31:0] exp_ht4;

  clk_period_meter dut (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .enable    (enable),
    .timeout   (timeout),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid) begin
      valid_cnt      = valid_cnt + 1;
      last_gap       = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (stall) stall_cnt = stall_cnt + 1;
    if (valid && stall) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int hi, input int lo, input int reps);
    repeat (reps) begin
      clk_in = 1'b1;
      tick(hi);
      clk_in = 1'b0;
      tick(lo);
    end
  endtask

  initial begin
`ifdef CLK_PERIOD_METER_DUTY_EN
    exp_ht5 = 32'd5;
    exp_ht4 = 32'd4;
`else
    exp_ht5 = 32'd0;
    exp_ht4 = 32'd0;
`endif
    rst     = 1'b0;
    enable  = 1'b0;
    clk_in  = 1'b0;
    timeout = 32'd0;
    tick(2);
    check("reset_period",    period,    32'd0);
    check("reset_high_time", high_time, 32'd0);
    check("reset_valid",     {31'd0, valid},  32'd0);
    check("reset_locked",    {31'd0, locked}, 32'd0);
    check("reset_stall",     {31'd0, stall},  32'd0);
    rst = 1'b1;
    tick(2);

    // 50% duty, period 10: five valid pulses from six driven rises.
    enable = 1'b1;
    tick(2);
    v0 = valid_cnt;
    drive_period(5, 5, 6);
    check("p10_valid_count", valid_cnt - v0, 32'd5);
    check("p10_gap",         last_gap,       32'd10);
    check("p10_period",      period,         32'd10);
    check("p10_high_time",   high_time,      exp_ht5);
    check("p10_locked",      {31'd0, locked}, 32'd1);

    // Period 7, high 4 / low 3.
    drive_period(4, 3, 4);
    check("p7_period",    period,    32'd7);
    check("p7_high_time", high_time, exp_ht4);
    check("p7_gap",       last_gap,  32'd7);

    // Stall: timeout 50, clk_in held low after the last rise.
    timeout = 32'd50;
    drive_period(5, 5, 3);
    check("pre_stall_period", period, 32'd10);
    s0 = stall_cnt;
    tick(42);
    check("stall_not_yet",        {31'd0, stall},  32'd0);
    check("locked_before_stall",  {31'd0, locked}, 32'd1);
    tick(1);
    check("stall_pulse",          {31'd0, stall},  32'd1);
    check("locked_after_stall",   {31'd0, locked}, 32'd0);
    check("period_after_stall",   period,          32'd10);
    tick(1);
    check("stall_one_cycle",      {31'd0, stall},  32'd0);
    check("stall_count",          stall_cnt - s0,  32'd1);

    // Resume: the first rise only arms, the second locks.
    drive_period(5, 5, 1);
    check("resume_one_rise_unlocked", {31'd0, locked}, 32'd0);
    drive_period(5, 5, 2);
    check("resume_locked", {31'd0, locked}, 32'd1);
    check("resume_period", period,          32'd10);

    // Timeout equals the period: the rise wins every time.
    timeout = 32'd10;
    v0 = valid_cnt;
    s0 = stall_cnt;
    drive_period(5, 5, 5);
    check("tmo_eq_valid_count", valid_cnt - v0, 32'd5);
    check("tmo_eq_no_stall",    stall_cnt - s0, 32'd0);
    check("tmo_eq_locked",      {31'd0, locked}, 32'd1);
    check("tmo_eq_period",      period,          32'd10);

    // Asynchronous reset mid-measurement.
    timeout = 32'd0;
    clk_in  = 1'b1;
    tick(3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_period",    period,    32'd0);
    check("async_rst_high_time", high_time, 32'd0);
    check("async_rst_locked",    {31'd0, locked}, 32'd0);
    check("async_rst_valid",     {31'd0, valid},  32'd0);
    check("async_rst_stall",     {31'd0, stall},  32'd0);
    clk_in = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    v0 = valid_cnt;
    drive_period(5, 5, 1);
    check("post_rst_one_rise_no_valid", valid_cnt - v0, 32'd0);
    check("post_rst_one_rise_period",   period,         32'd0);
    drive_period(5, 5, 1);
    check("post_rst_two_rises_valid",   valid_cnt - v0, 32'd1);
    check("post_rst_period",            period,         32'd10);
    check("post_rst_locked",            {31'd0, locked}, 32'd1);

    // Disable while locked; period holds, re-arm needs two rises.
    drive_period(5, 5, 1);
    enable = 1'b0;
    tick(1);
    check("disable_unlock",      {31'd0, locked}, 32'd0);
    check("disable_period_hold", period,          32'd10);
    v0 = valid_cnt;
    drive_period(5, 5, 3);
    check("disabled_no_valid",   valid_cnt - v0, 32'd0);
    check("disabled_period",     period,         32'd10);
    enable = 1'b1;
    drive_period(4, 4, 1);
    check("rearm_one_rise_no_valid", valid_cnt - v0, 32'd0);
    drive_period(4, 4, 1);
    check("rearm_valid",     valid_cnt - v0, 32'd1);
    check("rearm_period",    period,         32'd8);
    check("rearm_high_time", high_time,      exp_ht4);
    check("rearm_locked",    {31'd0, locked}, 32'd1);

    // A newly lowered timeout applies at the next comparison.
    tick(20);
    check("late_tmo_no_stall_yet", {31'd0, stall}, 32'd0);
    timeout = 32'd5;
    tick(1);
    check("late_tmo_stall",  {31'd0, stall},  32'd1);
    check("late_tmo_locked", {31'd0, locked}, 32'd0);
    check("late_tmo_period", period,          32'd8);

    tick(2);
    check("never_valid_and_stall", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
